// File: rtl/axi_burst_master_if.sv
// AXI4 AW/W/B/AR/R channel bundle between axi_burst_master and an AXI slave.
interface axi_burst_master_if #(
   parameter int unsigned ADDR_BITWIDTH = 32,
   parameter int unsigned DATA_BITWIDTH = 32,
   parameter int unsigned ID_BITWIDTH   = 1
);
   localparam int unsigned STRB_BITWIDTH = DATA_BITWIDTH / 8;

   logic                     TRAN_AWVALID;
   logic                     TRAN_AWREADY;
   logic [ADDR_BITWIDTH-1:0] TRAN_AWADDR;
   logic [ID_BITWIDTH-1:0]   TRAN_AWID;
   logic [7:0]               TRAN_AWLEN;
   logic [2:0]               TRAN_AWSIZE;
   logic [1:0]               TRAN_AWBURST;

   logic                     TRAN_WVALID;
   logic                     TRAN_WREADY;
   logic [DATA_BITWIDTH-1:0] TRAN_WDATA;
   logic [STRB_BITWIDTH-1:0] TRAN_WSTRB;
   logic                     TRAN_WLAST;

   logic                     TRAN_BVALID;
   logic                     TRAN_BREADY;
   logic [1:0]               TRAN_BRESP;
   logic [ID_BITWIDTH-1:0]   TRAN_BID;

   logic                     TRAN_ARVALID;
   logic                     TRAN_ARREADY;
   logic [ADDR_BITWIDTH-1:0] TRAN_ARADDR;
   logic [ID_BITWIDTH-1:0]   TRAN_ARID;
   logic [7:0]               TRAN_ARLEN;
   logic [2:0]               TRAN_ARSIZE;
   logic [1:0]               TRAN_ARBURST;

   logic                     TRAN_RVALID;
   logic                     TRAN_RREADY;
   logic [DATA_BITWIDTH-1:0] TRAN_RDATA;
   logic                     TRAN_RLAST;
   logic [ID_BITWIDTH-1:0]   TRAN_RID;
   logic [1:0]               TRAN_RRESP;

   modport master (
      output TRAN_AWVALID, TRAN_AWADDR, TRAN_AWID, TRAN_AWLEN, TRAN_AWSIZE, TRAN_AWBURST,
      input  TRAN_AWREADY,
      output TRAN_WVALID, TRAN_WDATA, TRAN_WSTRB, TRAN_WLAST,
      input  TRAN_WREADY,
      input  TRAN_BVALID, TRAN_BRESP, TRAN_BID,
      output TRAN_BREADY,
      output TRAN_ARVALID, TRAN_ARADDR, TRAN_ARID, TRAN_ARLEN, TRAN_ARSIZE, TRAN_ARBURST,
      input  TRAN_ARREADY,
      input  TRAN_RVALID, TRAN_RDATA, TRAN_RLAST, TRAN_RID, TRAN_RRESP,
      output TRAN_RREADY
   );

   modport slave (
      input  TRAN_AWVALID, TRAN_AWADDR, TRAN_AWID, TRAN_AWLEN, TRAN_AWSIZE, TRAN_AWBURST,
      output TRAN_AWREADY,
      input  TRAN_WVALID, TRAN_WDATA, TRAN_WSTRB, TRAN_WLAST,
      output TRAN_WREADY,
      output TRAN_BVALID, TRAN_BRESP, TRAN_BID,
      input  TRAN_BREADY,
      input  TRAN_ARVALID, TRAN_ARADDR, TRAN_ARID, TRAN_ARLEN, TRAN_ARSIZE, TRAN_ARBURST,
      output TRAN_ARREADY,
      output TRAN_RVALID, TRAN_RDATA, TRAN_RLAST, TRAN_RID, TRAN_RRESP,
      input  TRAN_RREADY
   );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst initiator: one read or write command at a time from a local port.
// Optional watchdog enabled by defining AXI_BURST_MASTER_TIMEOUT_EN.
module axi_burst_master #(
   parameter int unsigned ADDR_BITWIDTH  = 32,
   parameter int unsigned DATA_BITWIDTH  = 32,
   parameter int unsigned ID_BITWIDTH    = 1,
   parameter int unsigned W_DELAY        = 2
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_rnw,
   input  logic [ADDR_BITWIDTH-1:0] cmd_addr,
   input  logic [7:0]               cmd_len,
   input  logic [2:0]               cmd_size,
   input  logic [ID_BITWIDTH-1:0]   cmd_id,
   input  logic [DATA_BITWIDTH-1:0] wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [DATA_BITWIDTH-1:0] rd_data,
   output logic                     rd_valid,
   output logic                     rd_last,
   input  logic                     rd_ready,
   output logic                     done,
   output logic [1:0]               status_resp,
   output logic                     status_err,
   axi_burst_master_if.master       axi
);

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_WGAP, S_W, S_B, S_AR, S_R
   } state_t;

   state_t                   state;
   logic [ADDR_BITWIDTH-1:0] addr_q;
   logic [7:0]               len_q;
   logic [2:0]               size_q;
   logic [ID_BITWIDTH-1:0]   id_q;
   logic [7:0]               beat_cnt;
   logic [3:0]               gap_cnt;
   logic                     awvalid_q;
   logic                     arvalid_q;
   logic                     bready_q;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic last_beat;
   logic [1:0] rresp_max;
   logic timeout_hit;

   assign aw_hs     = awvalid_q & axi.TRAN_AWREADY;
   assign w_hs      = (state == S_W) & wr_valid & axi.TRAN_WREADY;
   assign b_hs      = bready_q & axi.TRAN_BVALID;
   assign ar_hs     = arvalid_q & axi.TRAN_ARREADY;
   assign r_hs      = (state == S_R) & rd_ready & axi.TRAN_RVALID;
   assign last_beat = (beat_cnt == len_q);
   assign rresp_max = (axi.TRAN_RRESP > status_resp) ? axi.TRAN_RRESP : status_resp;

   // Address channels come straight from the latched command.
   assign axi.TRAN_AWVALID = awvalid_q;
   assign axi.TRAN_AWADDR  = addr_q;
   assign axi.TRAN_AWID    = id_q;
   assign axi.TRAN_AWLEN   = len_q;
   assign axi.TRAN_AWSIZE  = size_q;
   assign axi.TRAN_AWBURST = 2'b01;
   assign axi.TRAN_ARVALID = arvalid_q;
   assign axi.TRAN_ARADDR  = addr_q;
   assign axi.TRAN_ARID    = id_q;
   assign axi.TRAN_ARLEN   = len_q;
   assign axi.TRAN_ARSIZE  = size_q;
   assign axi.TRAN_ARBURST = 2'b01;
   assign axi.TRAN_BREADY  = bready_q;

   // Data beats pass through combinationally while the matching state is active.
   assign axi.TRAN_WVALID  = (state == S_W) & wr_valid;
   assign axi.TRAN_WDATA   = wr_data;
   assign axi.TRAN_WSTRB   = '1;
   assign axi.TRAN_WLAST   = (state == S_W) & last_beat;
   assign wr_ready         = (state == S_W) & axi.TRAN_WREADY;
   assign axi.TRAN_RREADY  = (state == S_R) & rd_ready;
   assign rd_valid         = (state == S_R) & axi.TRAN_RVALID;
   assign rd_data          = axi.TRAN_RDATA;
   assign rd_last          = (state == S_R) & axi.TRAN_RLAST;

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
   logic [15:0] wd_cnt;
   logic        wd_active;
   logic        chan_hs;

   assign wd_active   = (state == S_AW) | (state == S_W) | (state == S_B) |
                        (state == S_AR) | (state == S_R);
   assign chan_hs     = aw_hs | w_hs | b_hs | ar_hs | r_hs;
   assign timeout_hit = wd_active & ~chan_hs & (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

   // Counts consecutive stalled cycles on the active channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= '0;
      end else if (!wd_active || chan_hs || timeout_hit) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cmd_ready   <= 1'b0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         id_q        <= '0;
         beat_cnt    <= '0;
         gap_cnt     <= '0;
         awvalid_q   <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         done        <= 1'b0;
         status_resp <= '0;
         status_err  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready   <= 1'b0;
                  addr_q      <= cmd_addr;
                  len_q       <= cmd_len;
                  size_q      <= cmd_size;
                  id_q        <= cmd_id;
                  status_resp <= '0;
                  status_err  <= 1'b0;
                  if (cmd_rnw) begin
                     arvalid_q <= 1'b1;
                     state     <= S_AR;
                  end else begin
                     awvalid_q <= 1'b1;
                     state     <= S_AW;
                  end
               end
            end
            S_AW: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  gap_cnt   <= '0;
                  state     <= (W_DELAY == 0) ? S_W : S_WGAP;
               end
            end
            // Lets the slave register AW before the first W beat is offered.
            S_WGAP: begin
               if (gap_cnt == 4'(W_DELAY - 1)) begin
                  state <= S_W;
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            S_W: begin
               if (w_hs) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     bready_q <= 1'b1;
                     state    <= S_B;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            S_B: begin
               if (b_hs) begin
                  bready_q    <= 1'b0;
                  status_resp <= axi.TRAN_BRESP;
                  status_err  <= status_err | (axi.TRAN_BID != id_q);
                  done        <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_AR: begin
               if (ar_hs) begin
                  arvalid_q <= 1'b0;
                  state     <= S_R;
               end
            end
            // Exit is driven by the beat count; a misplaced RLAST only flags an error.
            S_R: begin
               if (r_hs) begin
                  status_resp <= rresp_max;
                  status_err  <= status_err | (axi.TRAN_RID != id_q) |
                                 (axi.TRAN_RLAST != last_beat);
                  if (last_beat) begin
                     beat_cnt <= '0;
                     done     <= 1'b1;
                     state    <= S_IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + 8'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase

         if (timeout_hit) begin
            awvalid_q  <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            beat_cnt   <= '0;
            status_err <= 1'b1;
            done       <= 1'b1;
            state      <= S_IDLE;
         end
      end
   end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Synthesizable AXI4 burst initiator; the driving end for the team's AXI slave memory model.
- Accepts one command at a time (read or write, INCR burst) from a local command port.
- Write path: issues AW, then streams W beats from a local write-data port, then collects B.
- Read path: issues AR, then forwards R beats to a local read-data port.
- Sits between test sequencers or accelerators and the AXI fabric.

Parameters:
ADDR_BITWIDTH, 32, address width
DATA_BITWIDTH, 32, data width; WSTRB width is DATA_BITWIDTH/8
ID_BITWIDTH, 1, AXI ID width
W_DELAY, 2, idle cycles between AW handshake and first WVALID (0-15)
TIMEOUT_CYCLES, 256, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_rnw  in  1  1=read, 0=write
cmd_addr  in  ADDR_BITWIDTH  start address
cmd_len  in  8  beats-1
cmd_size  in  3  log2 bytes per beat
cmd_id  in  ID_BITWIDTH  transaction ID
wr_data / wr_valid / wr_ready  in/in/out  DATA_BITWIDTH/1/1  write beat stream
rd_data / rd_valid / rd_last / rd_ready  out/out/out/in  DATA_BITWIDTH/1/1/1  read beat stream
done  out  1  one-cycle pulse at transaction end
status_resp  out  2  worst BRESP/RRESP seen in the transaction
status_err  out  1  protocol error (ID mismatch, RLAST misplaced, timeout)
TRAN_AWVALID/AWREADY/AWADDR/AWID/AWLEN/AWSIZE/AWBURST  out/in/out/out/out/out/out  AXI AW
TRAN_WVALID/WREADY/WDATA/WSTRB/WLAST  out/in/out/out/out  AXI W
TRAN_BVALID/BREADY/BRESP/BID  in/out/in/in  AXI B
TRAN_ARVALID/ARREADY/ARADDR/ARID/ARLEN/ARSIZE/ARBURST  out/in/out/out/out/out/out  AXI AR
TRAN_RVALID/RREADY/RDATA/RLAST/RID/RRESP  in/out/in/in/in/in  AXI R

Behaviour:
- Reset (reset==1 at posedge): state IDLE. All VALID/READY outputs 0, done=0, status_resp=0, status_err=0, counters 0. Addr/len/size/id outputs 0.
- Reset mid-transaction aborts immediately; no handshake is completed.
- FSM states: IDLE, AW, WGAP, W, B, AR, R.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the command fields, clear status_resp/status_err.
  - Go to AR if rnw=1, else AW.
- AW / AR:
  - VALID=1 from the first cycle in the state.
  - ADDR/ID/LEN/SIZE are driven from the latched fields; BURST=2'b01.
  - VALID and fields are held stable until READY. On the handshake cycle, drop VALID next cycle.
  - Transitions: AW->WGAP, or AW->W directly if W_DELAY=0; AR->R.
- WGAP: counts W_DELAY cycles, then goes to W. Reason: the slave registers AW before accepting W.
- W:
  - Combinational: TRAN_WVALID=wr_valid, TRAN_WDATA=wr_data, wr_ready=TRAN_WREADY.
  - WSTRB all ones. WLAST = (beat_cnt==len).
  - beat_cnt (8 bit) increments per WVALID&WREADY.
  - The handshake on the last beat moves to B.
  - Outside W: TRAN_WVALID=0, wr_ready=0.
- B:
  - BREADY=1 for the whole state.
  - On BVALID: status_resp=BRESP; status_err |= (BID!=id); done=1 for one cycle; go to IDLE.
- R:
  - Combinational: TRAN_RREADY=rd_ready, rd_valid=TRAN_RVALID, rd_data=TRAN_RDATA, rd_last=TRAN_RLAST.
  - Per handshake:
    - beat_cnt++.
    - status_resp=max(status_resp, RRESP).
    - status_err |= (RID!=id) or (RLAST != (beat_cnt==len)).
  - Exit on the handshake where beat_cnt==len: done=1, go to IDLE. The exit does not depend on RLAST.
- Status outputs hold their values until the next command is accepted.
- No back-to-back overlap: a new command is accepted at the earliest one cycle after done.
- len=0: a single beat, with WLAST/expected RLAST on beat 0.
- beat_cnt clears on leaving W/R.

Optional Feature:
- Macro: AXI_BURST_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts consecutive cycles in AW/W/B/AR/R with no handshake on that state's channel.
  - On reaching TIMEOUT_CYCLES: all VALID/READY outputs go 0, status_err=1, done pulses, FSM goes to IDLE.
  - The watchdog clears on every handshake and in IDLE/WGAP.
- Not defined: no watchdog logic exists; the FSM waits indefinitely.

Test Plan:
- Memory preset data[i]=2*i; read addr=0x8, size=2, len=3 -> rd_data 4,6,8,10, rd_last only on the 4th beat, done pulse, status_resp=0, status_err=0.
- Write addr=0x0, size=2, len=2, wr_data 0xA,0xB,0xC -> WLAST only on beat 3, one B accepted, done; read-back returns 0xA,0xB,0xC.
- Read len=3 with rd_ready toggling 1,0,1,0 -> no beat lost or duplicated, 4 beats total, done after the 4th handshake.
- Slave holds AWREADY=0 for 5 cycles -> AWVALID and AWADDR stable all 5 cycles, no WVALID before AW handshake + W_DELAY.
- Slave returns BID=1 for cmd_id=0 -> status_err=1, done still pulses; RLAST asserted on beat 1 of len=3 -> status_err=1.
- With AXI_BURST_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, ARREADY held 0 -> done and status_err at cycle 16, ARVALID=0 afterwards, cmd_ready=1. Reset asserted mid-W -> all outputs at reset values next cycle.
